cart_image_loader: RTL and testbench

- Write-side counterpart of the cartridge ROM read path.
- Accepts a byte stream carrying a Game Boy cartridge image (host/UART/SD front end) and writes it sequentially into the 256 KiB cart memory as four 64 KiB banks selected by addr[17:16].
- Validates the header checksum on the fly and holds the console in reset until loading completes.

---
 rtl/cart_pkg.sv | 9 +
 rtl/cart_hdr_checksum.sv | 36 +++
 rtl/cart_image_loader.sv | 108 ++++++++++
 tb/tb_cart_image_loader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared types and header-checksum constants for the cartridge image loader.
package cart_pkg;
  localparam int          CART_ADDR_W = 18;
  localparam logic [15:0] HDR_START   = 16'h0134;
  localparam logic [15:0] HDR_END     = 16'h014C;
  localparam logic [15:0] HDR_CKSUM   = 16'h014D;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} cart_state_e;
endpackage

// File: rtl/cart_hdr_checksum.sv
// Running Game Boy header checksum: acc = acc - byte - 1 over the header
// range, plus a latch for the checksum byte stored in the image.
module cart_hdr_checksum import cart_pkg::*; #(
  parameter int CNT_W   = CART_ADDR_W + 1,
  parameter int LO_ADDR = int'(HDR_START),
  parameter int HI_ADDR = int'(HDR_END),
  parameter int CK_ADDR = int'(HDR_CKSUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] cnt,
  input  logic [7:0]       in_byte,
  input  logic             acc_stb,
  output logic             match
);
  localparam logic [CNT_W-1:0] LO = CNT_W'(LO_ADDR);
  localparam logic [CNT_W-1:0] HI = CNT_W'(HI_ADDR);
  localparam logic [CNT_W-1:0] CK = CNT_W'(CK_ADDR);

  logic [7:0] acc_q;
  logic [7:0] stored_q;

  // Accumulate header bytes and capture the stored checksum as they stream by.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_q    <= 8'h00;
      stored_q <= 8'h00;
    end else if (acc_stb) begin
      if (cnt >= LO && cnt <= HI) acc_q <= acc_q - in_byte - 8'd1;
      if (cnt == CK) stored_q <= in_byte;
    end
  end

  assign match = (acc_q == stored_q);
endmodule

// File: rtl/cart_image_loader.sv
// Streams a cartridge image into cart memory, one byte per accepted input,
// validates the header checksum and holds the console in reset while busy.
module cart_image_loader import cart_pkg::*; #(
  parameter int          ADDR_W      = CART_ADDR_W,
  parameter int          IMAGE_BYTES = 262144,
  parameter logic [15:0] HDR_START   = cart_pkg::HDR_START,
  parameter logic [15:0] HDR_END     = cart_pkg::HDR_END,
  parameter logic [15:0] HDR_CKSUM   = cart_pkg::HDR_CKSUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              hdr_ok,
  output logic              err
);
  // One extra counter bit so a full 2^ADDR_W image ends without wrapping.
  localparam int               CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(IMAGE_BYTES - 1);

  cart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, take, clr, match;

  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q == LOAD) || (state_q == CHECK);
  assign done     = (state_q == DONE);
  assign accept   = in_valid & in_ready;
  // A byte accepted alongside abort is dropped entirely.
  assign take     = accept & ~abort;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; clr marks the fresh-load clear on start.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = LOAD;
        clr     = 1'b1;
      end
      LOAD: begin
        if (abort)                      state_d = IDLE;
        else if (accept && cnt_q == LAST) state_d = CHECK;
      end
      CHECK:   state_d = abort ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // Byte counter and the one-cycle-delayed memory write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'h00;
    end else begin
      wr_en <= take;
      if (clr) begin
        cnt_q <= '0;
      end else if (take) begin
        cnt_q   <= cnt_q + 1'b1;
        wr_addr <= cnt_q[ADDR_W-1:0];
        wr_data <= in_data;
      end
    end
  end

  // Sticky status flags; hdr_ok is sampled on the CHECK cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err    <= 1'b0;
      hdr_ok <= 1'b0;
    end else begin
      if (abort && busy) err <= 1'b1;
      if (state_q == CHECK && !abort) hdr_ok <= match;
    end
  end

  cart_hdr_checksum #(
    .CNT_W   (CNT_W),
    .LO_ADDR (int'(HDR_START)),
    .HI_ADDR (int'(HDR_END)),
    .CK_ADDR (int'(HDR_CKSUM))
  ) u_cksum (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .cnt     (cnt_q),
    .in_byte (in_data),
    .acc_stb (take),
    .match   (match)
  );
endmodule

// File: tb/tb_cart_image_loader.sv
// Bench for cart_image_loader with a 512-byte image in a 9-bit address space
// (image fills the whole address range, exercising the no-wrap boundary).
module tb_cart_image_loader;
  localparam int IMG = 512;
  localparam int AW  = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, wr_en, busy, done, hdr_ok, err;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  always #5 clk = ~clk;

  cart_image_loader #(.ADDR_W(AW), .IMAGE_BYTES(IMG)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .busy(busy), .done(done), .hdr_ok(hdr_ok), .err(err)
  );

  int n_checks = 0, n_err = 0, n_wr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] img [IMG];
  bit m_vld = 0, m_loading = 0, m_checking = 0, m_done = 0, m_err = 0, m_ok = 0, m_wr_en = 0;
  int m_cnt = 0, m_wa = 0;
  logic [7:0] m_wd = 8'h00;

  // Header checksum from the written image: 0 - sum(b+1) over 0x134..0x14C.
  function automatic bit hdr_calc();
    int s = 0;
    for (int k = 'h134; k <= 'h14C; k++) s += int'(img[k]) + 1;
    return 8'(-s) == img['h14D];
  endfunction

  always @(posedge clk) begin
    m_wr_en = 0;
    if (rst) begin
      m_loading = 0; m_checking = 0; m_done = 0; m_err = 0; m_ok = 0; m_cnt = 0;
      m_wa = 0; m_wd = 8'h00;
    end else if (m_loading) begin
      if (abort) begin
        m_loading = 0; m_err = 1;
      end else if (in_valid) begin
        m_wr_en = 1; m_wa = m_cnt; m_wd = in_data;
        img[m_cnt] = in_data;
        m_cnt++;
        if (m_cnt == IMG) begin m_loading = 0; m_checking = 1; end
      end
    end else if (m_checking) begin
      m_checking = 0;
      if (abort) m_err = 1;
      else begin m_done = 1; m_ok = hdr_calc(); end
    end else if (start) begin
      m_loading = 1; m_done = 0; m_err = 0; m_ok = 0; m_cnt = 0;
    end
    m_vld = 1;
  end

  // Compare DUT against the model every cycle.
  always @(negedge clk) begin
    if (m_vld) begin
      chk("in_ready", in_ready, m_loading);
      chk("busy", busy, m_loading | m_checking);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("wr_en", wr_en, m_wr_en);
      if (m_wr_en) begin
        chk("wr_addr", wr_addr, m_wa);
        chk("wr_data", wr_data, m_wd);
      end
      if (m_done) chk("hdr_ok", hdr_ok, m_ok);
      if (wr_en) n_wr++;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] dat [IMG];

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] pattern(input int mode, input int k);
    logic [7:0] kb;
    kb = k[7:0];
    case (mode)
      0: return kb;
      1, 2: begin
        if (k >= 'h134 && k <= 'h14C) return 8'h00;
        if (k == 'h14D) return (mode == 1) ? 8'hE7 : 8'hE6;
        return kb ^ 8'h5A;
      end
      default: return 8'($urandom);
    endcase
  endfunction

  // mode 3 throttles in_valid as 1,0,0,1; *_at = -1 disables that event.
  task automatic feed(input int mode, input int abort_at, input int start_at, input int rst_at);
    int i, t, w;
    bit v;
    for (int k = 0; k < IMG; k++) dat[k] = pattern(mode, k);
    n_wr = 0;
    start = 1; step(); start = 0;
    i = 0; t = 0;
    while (i < IMG && t < 4 * IMG + 16) begin
      v = (mode != 3) || (t % 4 == 0) || (t % 4 == 3);
      in_valid = v; in_data = dat[i];
      if (i == rst_at) begin
        rst = 1; step(); rst = 0; in_valid = 0;
        return;
      end
      abort = v && (i == abort_at);
      start = v && (i == start_at);
      step();
      start = 0;
      if (abort) begin abort = 0; in_valid = 0; return; end
      if (v) i++;
      t++;
    end
    in_valid = 0;
    chk("feed_timeout", i, IMG);
    w = 0;
    while (!done && w < 8) begin step(); w++; end
    chk("done_timeout", done, 1);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hdr_ok", hdr_ok, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    rst = 0; step();

    // Full image, data = addr[7:0]; stored 0x4D vs computed 0xA7 -> mismatch.
    feed(0, -1, -1, -1);
    chk("full_writes", n_wr, IMG);
    chk("full_busy", busy, 0);
    chk("full_hdr_ok", hdr_ok, 0);
    step();

    // Zero header: 0 - 25 = 0xE7.
    feed(1, -1, -1, -1);
    chk("hdr_pass", hdr_ok, 1);
    feed(2, -1, -1, -1);
    chk("hdr_fail", hdr_ok, 0);
    chk("hdr_fail_done", done, 1);

    feed(3, -1, -1, -1);
    chk("thr_writes", n_wr, IMG);

    feed(0, 100, -1, -1);
    step();
    chk("abort_writes", n_wr, 100);
    chk("abort_err", err, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    feed(0, -1, -1, -1);
    chk("reload_err", err, 0);
    chk("reload_done", done, 1);

    feed(0, -1, -1, 200);
    chk("mrst_wr_en", wr_en, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_wr_addr", wr_addr, 0);
    chk("mrst_err", err, 0);
    step();
    feed(1, -1, -1, -1);
    chk("mrst_reload_hdr", hdr_ok, 1);

    feed(0, -1, 50, -1);
    chk("istart_writes", n_wr, IMG);
    chk("istart_done", done, 1);

    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
